// File: rtl/segment_led_decoder.sv
// Receive side of the 7-segment bus: synchronizes and glitch-filters the segment pattern,
// decodes it back to a hex nibble plus DP, and reports non-hex patterns.
module segment_led_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8:0]           segment_in,
    input  logic                 out_ready,
    input  logic                 clr_err,
    output logic [3:0]           seg_data,
    output logic                 dp,
    output logic                 out_valid,
    output logic                 code_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, FILTER, ACCEPT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [8:0]           sync1_q, s_q;
    logic [8:0]           cand_q, cand_d;
    logic [8:0]           last_acc_q, last_acc_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [3:0]           seg_data_q, seg_data_d;
    logic                 dp_q, dp_d;
    logic                 out_valid_q, out_valid_d;
    logic                 code_err_q, code_err_d;
    logic                 overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0]           hex_code;
    logic                 hex_hit;
    logic                 err_event;
    logic                 ovr_event;

    // Segment pattern (G..A) to hex nibble
    always_comb begin
        hex_code = 4'h0;
        hex_hit  = 1'b1;
        case (cand_q[6:0])
            7'h3f: hex_code = 4'h0;
            7'h06: hex_code = 4'h1;
            7'h5b: hex_code = 4'h2;
            7'h4f: hex_code = 4'h3;
            7'h66: hex_code = 4'h4;
            7'h6d: hex_code = 4'h5;
            7'h7d: hex_code = 4'h6;
            7'h07: hex_code = 4'h7;
            7'h7f: hex_code = 4'h8;
            7'h6f: hex_code = 4'h9;
            7'h77: hex_code = 4'ha;
            7'h7c: hex_code = 4'hb;
            7'h39: hex_code = 4'hc;
            7'h5e: hex_code = 4'hd;
            7'h79: hex_code = 4'he;
            7'h71: hex_code = 4'hf;
            default: hex_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        last_acc_d  = last_acc_q;
        cnt_d       = cnt_q;
        seg_data_d  = seg_data_q;
        dp_d        = dp_q;
        out_valid_d = out_valid_q;
        code_err_d  = 1'b0;
        overrun_d   = overrun_q;
        err_cnt_d   = err_cnt_q;
        err_event   = 1'b0;
        ovr_event   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_q != last_acc_q) begin
                    state_d = FILTER;
                    cand_d  = s_q;
                    cnt_d   = 8'd1;
                end
            end
            FILTER: begin
                if (s_q != cand_q) begin
                    // Bouncing back to the accepted pattern is not a new event
                    if (s_q == last_acc_q) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = s_q;
                        cnt_d  = 8'd1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ACCEPT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACCEPT: begin
                state_d    = IDLE;
                last_acc_d = cand_q;
                if (cand_q[8]) begin
                    if (hex_hit) begin
                        if (!out_valid_q || out_ready) begin
                            seg_data_d  = hex_code;
                            dp_d        = cand_q[7];
                            out_valid_d = 1'b1;
                        end else begin
                            ovr_event = 1'b1;
                        end
                    end else begin
                        err_event = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear coinciding with a new event keeps the event
        if (clr_err) begin
            err_cnt_d = '0;
            overrun_d = 1'b0;
        end
        if (err_event) begin
            code_err_d = 1'b1;
            if (clr_err) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
        if (ovr_event) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 9'h000;
            s_q         <= 9'h000;
            cand_q      <= 9'h000;
            last_acc_q  <= 9'h000;
            cnt_q       <= 8'd0;
            seg_data_q  <= 4'h0;
            dp_q        <= 1'b0;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= segment_in;
            s_q         <= sync1_q;
            cand_q      <= cand_d;
            last_acc_q  <= last_acc_d;
            cnt_q       <= cnt_d;
            seg_data_q  <= seg_data_d;
            dp_q        <= dp_d;
            out_valid_q <= out_valid_d;
            code_err_q  <= code_err_d;
            overrun_q   <= overrun_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign seg_data  = seg_data_q;
    assign dp        = dp_q;
    assign out_valid = out_valid_q;
    assign code_err  = code_err_q;
    assign overrun   = overrun_q;
    assign err_cnt   = err_cnt_q;

endmodule
